// File: rtl/bidir_pad_ctrl.sv
// Direction controller for a bus of bidirectional pad cells: arbitrates one writer
// and one reader, inserts turnaround cycles and synchronises pad input.

module bidir_pad_lane #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_d,
  input  logic dout_d,
  input  logic din,
  output logic en_q,
  output logic dout_q,
  output logic sync_q
);
  logic [SYNC_STAGES-1:0] sync_chain_q, sync_chain_d;

  // pad_din is asynchronous to clk; the chain runs in every state
  always_comb sync_chain_d = {sync_chain_q[SYNC_STAGES-2:0], din};
  assign sync_q = sync_chain_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q         <= 1'b0;
      dout_q       <= 1'b0;
      sync_chain_q <= '0;
    end else begin
      en_q         <= en_d;
      dout_q       <= dout_d;
      sync_chain_q <= sync_chain_d;
    end
  end
endmodule

module bidir_pad_ctrl #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYC    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             rd_req,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] pad_en,
  output logic [WIDTH-1:0] pad_dout,
  input  logic [WIDTH-1:0] pad_din,
  output logic             busy
);
  localparam int CNT_MAX = (TURN_CYC > SYNC_STAGES) ? TURN_CYC : SYNC_STAGES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYC - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_STAGES - 1);

  typedef enum logic [2:0] {IDLE, TX_TURN, TX, RX_TURN, RX_SYNC} state_e;
  typedef enum logic {GR_READ, GR_WRITE} grant_e;
  typedef struct packed {
    logic wr;
    logic rd;
  } arb_t;

  state_e           state_q, state_d;
  grant_e           last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             pad_en_d;
  logic [WIDTH-1:0] pad_dout_d;
  logic [WIDTH-1:0] din_sync;
  arb_t             arb;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    bidir_pad_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_d   (pad_en_d),
      .dout_d (pad_dout_d[i]),
      .din    (pad_din[i]),
      .en_q   (pad_en[i]),
      .dout_q (pad_dout[i]),
      .sync_q (din_sync[i])
    );
  end

  always_comb begin
    // on a conflict the side that did not win last time gets the bus
    arb.wr       = wr_valid && (!rd_req || last_grant_q == GR_READ);
    arb.rd       = rd_req && (!wr_valid || last_grant_q == GR_WRITE);
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    pad_dout_d   = pad_dout;
    wr_ready     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb.wr) begin
          wr_ready     = 1'b1;
          pad_dout_d   = wr_data;
          last_grant_d = GR_WRITE;
          cnt_d        = '0;
          state_d      = TX_TURN;
        end else if (arb.rd) begin
          last_grant_d = GR_READ;
          cnt_d        = '0;
          state_d      = RX_TURN;
        end
      end
      TX_TURN: begin
        if (cnt_q == TURN_LAST) begin
          cnt_d   = '0;
          state_d = TX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TX: begin
        // reads are never granted here; a losing write falls back to IDLE
        if (arb.wr) begin
          wr_ready     = 1'b1;
          pad_dout_d   = wr_data;
          last_grant_d = GR_WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      RX_TURN: begin
        if (cnt_q == TURN_LAST) begin
          cnt_d   = '0;
          state_d = RX_SYNC;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_SYNC: begin
        if (cnt_q == SYNC_LAST) begin
          rd_data_d  = din_sync;
          rd_valid_d = 1'b1;
          cnt_d      = '0;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst_n) wr_ready = 1'b0;
    pad_en_d = (state_d == TX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GR_READ;
      cnt_q        <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q != IDLE);

  a_pad_en_only_tx: assert property (@(posedge clk) disable iff (!rst_n)
    (pad_en != '0) |-> (state_q == TX && pad_en == '1));
endmodule
